// File: rtl/wb_master_pkg.sv
// Shared types and helpers for the Wishbone classic-cycle master.
package wb_master_pkg;

    localparam int unsigned WB_TIMEOUT_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_e;

    // Ceiling log2 that never returns 0, so a 1-deep structure still gets a 1-bit index.
    function automatic int unsigned clog2_safe(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/wb_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit to tell full from empty.
module wb_cmd_fifo
    import wb_master_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata_c,
    output logic             o_full_c,
    output logic             o_empty_c
);

    localparam int unsigned AW = clog2_safe(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign w_push    = i_push && !o_full_c;
    assign w_pop     = i_pop && !o_empty_c;
    assign o_empty_c = (r_wr_ptr == r_rd_ptr);
    assign o_full_c  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_rdata_c = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; simultaneous push and pop leave the occupancy unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage array; contents need no reset because empty pointers mask them.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/wb_master_ctrl.sv
// Wishbone classic-cycle master: buffered commands, one bus transfer at a time,
// one in-order response per command. Optional bus timeout via WB_MASTER_TIMEOUT_EN.
module wb_master_ctrl
    import wb_master_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned STRB_W      = DATA_W / 8,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_strb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [DATA_W-1:0] wb_dat_o,
    output logic [STRB_W-1:0] wb_sel_o,
    output logic              wb_we_o,
    output logic              wb_stb_o,
    output logic              wb_cyc_o,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i
);

    localparam int unsigned CMD_W = 1 + STRB_W + DATA_W + ADDR_W;

    wb_state_e         r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_adr, w_adr_nxt;
    logic [DATA_W-1:0] r_dat, w_dat_nxt;
    logic [STRB_W-1:0] r_sel, w_sel_nxt;
    logic              r_we, w_we_nxt;
    logic              r_cyc, w_cyc_nxt;
    logic              r_stb, w_stb_nxt;
    logic              r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
    logic              r_rsp_err, w_rsp_err_nxt;

    logic [CMD_W-1:0]  w_fifo_wdata;
    logic [CMD_W-1:0]  w_fifo_rdata;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_head_we;
    logic [STRB_W-1:0] w_head_strb;
    logic [DATA_W-1:0] w_head_wdata;
    logic [ADDR_W-1:0] w_head_addr;
    logic              w_tmo_hit;
    logic              w_bus_fail;

    assign w_fifo_wdata = {cmd_we, cmd_strb, cmd_wdata, cmd_addr};
    assign w_head_we    = w_fifo_rdata[CMD_W-1];
    assign w_head_strb  = w_fifo_rdata[CMD_W-2 -: STRB_W];
    assign w_head_wdata = w_fifo_rdata[ADDR_W +: DATA_W];
    assign w_head_addr  = w_fifo_rdata[0 +: ADDR_W];

    wb_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .i_push    (cmd_valid),
        .i_wdata   (w_fifo_wdata),
        .i_pop     (w_pop),
        .o_rdata_c (w_fifo_rdata),
        .o_full_c  (w_full),
        .o_empty_c (w_empty)
    );

`ifdef WB_MASTER_TIMEOUT_EN
    logic [WB_TIMEOUT_W-1:0] r_tmo_cnt;

    // Counts BUS cycles without a slave reply; held at zero outside BUS.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo_cnt <= '0;
        end else if (r_state != BUS) begin
            r_tmo_cnt <= '0;
        end else if (!wb_ack_i && !wb_err_i) begin
            r_tmo_cnt <= r_tmo_cnt + WB_TIMEOUT_W'(1);
        end
    end

    // The edge that would bring the count to TIMEOUT_CYC aborts the transfer.
    assign w_tmo_hit = (r_state == BUS) && !wb_ack_i && !wb_err_i &&
                       (r_tmo_cnt == WB_TIMEOUT_W'(TIMEOUT_CYC - 1));
`else
    logic [WB_TIMEOUT_W-1:0] w_unused_tmo;
    assign w_unused_tmo = WB_TIMEOUT_W'(TIMEOUT_CYC);
    assign w_tmo_hit    = 1'b0;
`endif

    assign w_bus_fail = wb_err_i || w_tmo_hit;

    // Next-state and next-output logic for the IDLE/BUS/RESP sequencer.
    always_comb begin
        w_state_nxt     = r_state;
        w_pop           = 1'b0;
        w_adr_nxt       = r_adr;
        w_dat_nxt       = r_dat;
        w_sel_nxt       = r_sel;
        w_we_nxt        = r_we;
        w_cyc_nxt       = r_cyc;
        w_stb_nxt       = r_stb;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_adr_nxt   = w_head_addr;
                    w_dat_nxt   = w_head_wdata;
                    w_sel_nxt   = w_head_strb;
                    w_we_nxt    = w_head_we;
                    w_cyc_nxt   = 1'b1;
                    w_stb_nxt   = 1'b1;
                    w_state_nxt = BUS;
                end
            end
            BUS: begin
                if (w_bus_fail || wb_ack_i) begin
                    w_adr_nxt       = '0;
                    w_dat_nxt       = '0;
                    w_sel_nxt       = '0;
                    w_we_nxt        = 1'b0;
                    w_cyc_nxt       = 1'b0;
                    w_stb_nxt       = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = w_bus_fail;
                    w_rsp_rdata_nxt = (w_bus_fail || r_we) ? '0 : wb_dat_i;
                    w_state_nxt     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_err_nxt   = 1'b0;
                    w_state_nxt     = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops the bus immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_adr       <= '0;
            r_dat       <= '0;
            r_sel       <= '0;
            r_we        <= 1'b0;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_adr       <= w_adr_nxt;
            r_dat       <= w_dat_nxt;
            r_sel       <= w_sel_nxt;
            r_we        <= w_we_nxt;
            r_cyc       <= w_cyc_nxt;
            r_stb       <= w_stb_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    assign cmd_ready = !w_full;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign wb_adr_o  = r_adr;
    assign wb_dat_o  = r_dat;
    assign wb_sel_o  = r_sel;
    assign wb_we_o   = r_we;
    assign wb_stb_o  = r_stb;
    assign wb_cyc_o  = r_cyc;

endmodule
